// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset controller: state encoding,
// opcodes, datapath select codes and the control-word layout.
package cpu_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned ST_W     = 4;

  typedef enum logic [ST_W-1:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXEC_R    = 4'd6,
    ALU_WB    = 4'd7,
    EXEC_I    = 4'd8,
    IMM_WB    = 4'd9,
    BRANCH    = 4'd10,
    JUMP      = 4'd11
  } state_e;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  localparam logic [1:0] SRCB_B       = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       reg_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/control_output_decode.sv
// Moore output decode: maps the controller state (plus mem_ready in FETCH and
// zero in BRANCH) onto the datapath control word.
module control_output_decode
  import cpu_pkg::*;
(
  input  logic [ST_W-1:0]   state_i,
  input  logic              mem_ready_i,
  input  logic              zero_i,
  output logic [CTRL_W-1:0] ctrl_o
);

  ctrl_t ctrl;

  always_comb begin
    ctrl = '0;
    case (state_e'(state_i))
      FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_src    = PCSRC_ALU;
        ctrl.ir_we     = mem_ready_i;
        ctrl.pc_we     = mem_ready_i;
      end
      // Branch target is precomputed into ALUOut while the opcode is decoded.
      DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALU_ADD;
      end
      MEM_ADDR, EXEC_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      MEM_READ: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      MEM_WB: begin
        ctrl.reg_we     = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      MEM_WRITE: begin
        ctrl.mem_req = 1'b1;
        ctrl.mem_we  = 1'b1;
        ctrl.iord    = 1'b1;
      end
      EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
      end
      ALU_WB: begin
        ctrl.reg_we  = 1'b1;
        ctrl.reg_dst = 1'b1;
      end
      IMM_WB: begin
        ctrl.reg_we = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.pc_we     = zero_i;
      end
      JUMP: begin
        ctrl.pc_src = PCSRC_JUMP;
        ctrl.pc_we  = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  assign ctrl_o = ctrl;

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle main controller: state register and next-state sequencing for
// fetch/decode/execute/memory/write-back with a stalling memory handshake.
module multicycle_control
  import cpu_pkg::*;
#(
  parameter int unsigned OPC_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             reg_we,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             illegal,
  output logic [3:0]       state
);

  state_e            state_q, state_d;
  logic              illegal_c;
  logic [CTRL_W-1:0] dec_ctrl;
  ctrl_t             ctrl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  // Request states hold until mem_ready; everything else falls back to FETCH.
  always_comb begin
    state_d   = FETCH;
    illegal_c = 1'b0;
    case (state_q)
      FETCH:     state_d = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = MEM_ADDR;
          OP_RTYPE:     state_d = EXEC_R;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = EXEC_I;
          OP_J:         state_d = JUMP;
          default: begin
            state_d   = FETCH;
            illegal_c = 1'b1;
          end
        endcase
      end
      MEM_ADDR: begin
        if (opcode == OP_LW)      state_d = MEM_READ;
        else if (opcode == OP_SW) state_d = MEM_WRITE;
        else                      state_d = FETCH;
      end
      MEM_READ:  state_d = mem_ready ? MEM_WB : MEM_READ;
      MEM_WRITE: state_d = mem_ready ? FETCH : MEM_WRITE;
      EXEC_R:    state_d = ALU_WB;
      EXEC_I:    state_d = IMM_WB;
      default:   state_d = FETCH;
    endcase
  end

  control_output_decode u_decode (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .zero_i      (zero),
    .ctrl_o      (dec_ctrl)
  );

  // Reset silences every strobe, including the otherwise-live FETCH request.
  assign ctrl = rst ? '0 : ctrl_t'(dec_ctrl);

  assign mem_req    = ctrl.mem_req;
  assign mem_we     = ctrl.mem_we;
  assign iord       = ctrl.iord;
  assign ir_we      = ctrl.ir_we;
  assign pc_we      = ctrl.pc_we;
  assign pc_src     = ctrl.pc_src;
  assign reg_we     = ctrl.reg_we;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign illegal    = illegal_c & ~rst;
  assign state      = state_q;

endmodule
